// File: rtl/minmax_int_stream_pkg.sv
// minmax_int_stream_pkg: shared state encoding and mode constants for the min/max stream reducer
package minmax_int_stream_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int MODE_MIN = 0;
    localparam int MODE_MAX = 1;
endpackage

// File: rtl/minmax_int_stream_lt.sv
// lt_int_nbit: signed a < b; IMPL_TYPE!=0 uses an offset-binary unsigned compare
module lt_int_nbit #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);
    if (IMPL_TYPE == 0) begin : g_signed
        assign lt = $signed(a) < $signed(b);
    end else begin : g_offset
        // flipping the sign bit maps two's complement onto an order-preserving unsigned range
        assign lt = {~a[WIDTH-1], a[WIDTH-2:0]} < {~b[WIDTH-1], b[WIDTH-2:0]};
    end
endmodule

// File: rtl/minmax_int_stream.sv
// minmax_int_stream: reduces a signed stream to its min (or max) value, first index and element count
module minmax_int_stream
    import minmax_int_stream_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 16,
    parameter int MODE_MAX  = 0,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_val,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [IDX_WIDTH-1:0] out_count,
    output logic                 out_ovf
);
    localparam bit IS_MAX = (MODE_MAX == minmax_int_stream_pkg::MODE_MAX);
    state_t               state;
    logic [WIDTH-1:0]     best;
    logic [IDX_WIDTH-1:0] best_idx;
    logic [IDX_WIDTH-1:0] count;
    logic                 ovf;
    logic                 better;
    logic                 acc;
    logic                 sat;
    // strict compare keeps the earliest of equal values
    lt_int_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_lt (
        .a (IS_MAX ? best : in_data),
        .b (IS_MAX ? in_data : best),
        .lt(better)
    );
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign out_val   = best;
    assign out_idx   = best_idx;
    assign out_count = count;
    assign out_ovf   = ovf;
    assign acc       = in_valid && in_ready;
    assign sat       = &count;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            best     <= '0;
            best_idx <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (acc) begin
                    best     <= in_data;
                    best_idx <= '0;
                    count    <= IDX_WIDTH'(1);
                    state    <= in_last ? DONE : ACCUM;
                end
                ACCUM: if (acc) begin
                    if (better) best <= in_data;
                    if (better && !sat) best_idx <= count;
                    if (sat) ovf <= 1'b1;
                    else count <= count + IDX_WIDTH'(1);
                    state <= in_last ? DONE : ACCUM;
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    ovf   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
